dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory (port 0 core, port 1 DMA/debug).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 0 wins.
module dmem_arbiter #(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 8192
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            p0_req_valid_i,
    output logic            p0_req_ready_o,
    input  logic            p0_we_i,
    input  logic [XLEN-1:0] p0_addr_i,
    input  logic [XLEN-1:0] p0_wdata_i,
    input  logic [1:0]      p0_size_i,
    input  logic            p0_sign_ext_i,
    output logic            p0_rsp_valid_o,
    input  logic            p0_rsp_ready_i,
    output logic [XLEN-1:0] p0_rdata_o,
    output logic            p0_rsp_err_o,
    input  logic            p1_req_valid_i,
    output logic            p1_req_ready_o,
    input  logic            p1_we_i,
    input  logic [XLEN-1:0] p1_addr_i,
    input  logic [XLEN-1:0] p1_wdata_i,
    input  logic [1:0]      p1_size_i,
    input  logic            p1_sign_ext_i,
    output logic            p1_rsp_valid_o,
    input  logic            p1_rsp_ready_i,
    output logic [XLEN-1:0] p1_rdata_o,
    output logic            p1_rsp_err_o,
    output logic            mem_write_en_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [1:0]      mem_size_o,
    output logic            mem_sign_ext_o,
    input  logic [XLEN-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    state_t state_reg, state_next;

    logic [1:0]      req_valid, we_in, sext_in, rsp_ready_in, req_ready, rsp_valid, rsp_err;
    logic [XLEN-1:0] addr_in [2];
    logic [XLEN-1:0] wdata_in [2];
    logic [1:0]      size_in [2];
    logic [XLEN-1:0] rdata_out [2];

    logic            grant_en, grant_sel, pick;
    logic            owner_reg, we_reg, sext_reg, err_reg;
    logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
    logic [1:0]      size_reg;
    logic            in_access, in_resp;

    logic [XLEN-1:0] sel_addr;
    logic [1:0]      sel_size;
    logic [XLEN:0]   req_bytes, sel_end;
    logic            req_err;

    assign req_valid    = {p1_req_valid_i, p0_req_valid_i};
    assign we_in        = {p1_we_i, p0_we_i};
    assign sext_in      = {p1_sign_ext_i, p0_sign_ext_i};
    assign rsp_ready_in = {p1_rsp_ready_i, p0_rsp_ready_i};
    assign addr_in[0]   = p0_addr_i;
    assign addr_in[1]   = p1_addr_i;
    assign wdata_in[0]  = p0_wdata_i;
    assign wdata_in[1]  = p1_wdata_i;
    assign size_in[0]   = p0_size_i;
    assign size_in[1]   = p1_size_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_grant_reg <= 1'b1;
        else if (grant_en)
            last_grant_reg <= grant_sel;
    end

    assign pick = (&req_valid) ? ~last_grant_reg : ~req_valid[0];
`else
    assign pick = ~req_valid[0];
`endif

    // Range check uses one extra bit so addr+bytes cannot wrap past the limit.
    assign sel_addr = addr_in[grant_sel];
    assign sel_size = size_in[grant_sel];
    always_comb begin
        req_bytes = '0;
        case (sel_size)
            2'b00:   req_bytes = (XLEN+1)'(1);
            2'b01:   req_bytes = (XLEN+1)'(2);
            default: req_bytes = (XLEN+1)'(4);
        endcase
    end
    assign sel_end = {1'b0, sel_addr} + req_bytes;
    assign req_err = (sel_size == 2'b11) || (sel_end > MEM_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        grant_sel  = pick;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_en   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (rsp_ready_in[owner_reg])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= 2'b00;
            rdata_reg <= '0;
        end else begin
            if (grant_en) begin
                owner_reg <= grant_sel;
                we_reg    <= we_in[grant_sel];
                sext_reg  <= sext_in[grant_sel];
                err_reg   <= req_err;
                addr_reg  <= sel_addr;
                wdata_reg <= wdata_in[grant_sel];
                size_reg  <= sel_size;
            end
            // Writes and faulted accesses always answer with zero data.
            if (state_reg == ACCESS)
                rdata_reg <= (we_reg || err_reg) ? '0 : mem_rdata_i;
        end
    end

    assign in_access = (state_reg == ACCESS) && !rst_i;
    assign in_resp   = (state_reg == RESP) && !rst_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi] = grant_en && (grant_sel == 1'(gi)) && !rst_i;
        assign rsp_valid[gi] = in_resp && (owner_reg == 1'(gi));
        assign rsp_err[gi]   = rsp_valid[gi] && err_reg;
        assign rdata_out[gi] = rsp_valid[gi] ? rdata_reg : '0;
    end

    assign p0_req_ready_o = req_ready[0];
    assign p1_req_ready_o = req_ready[1];
    assign p0_rsp_valid_o = rsp_valid[0];
    assign p1_rsp_valid_o = rsp_valid[1];
    assign p0_rsp_err_o   = rsp_err[0];
    assign p1_rsp_err_o   = rsp_err[1];
    assign p0_rdata_o     = rdata_out[0];
    assign p1_rdata_o     = rdata_out[1];

    assign mem_write_en_o = in_access && we_reg && !err_reg;
    assign mem_addr_o     = in_access ? addr_reg : '0;
    assign mem_wdata_o    = in_access ? wdata_reg : '0;
    assign mem_size_o     = in_access ? size_reg : 2'b00;
    assign mem_sign_ext_o = in_access && sext_reg;
endmodule
